mcac_chan_mem: RTL and testbench

Parametrised per-channel state memory for the multi-channel ADPCM codec, successor to the fixed `main_mem` shell. It holds `WORDS_PER_CH` state words for each of `NUM_CH` channels in one single-port flop array. Two requester ports (A: encoder, B: decoder) share the array under round-robin arbitration. The block also provides a power-up zeroing sweep and a per-channel clear command, and keeps the codebase's scan port set.

---
 rtl/mcac_mem_pkg.sv | 28 ++
 rtl/mcac_rr_arb2.sv | 29 ++
 rtl/mcac_chan_mem.sv | 190 +++++++++++++++++++
 tb/tb_mcac_chan_mem.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcac_mem_pkg.sv
// Shared types and helpers for the per-channel codec state memory.
package mcac_mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    // Bits needed to index v entries (v >= 2).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x != 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mcac_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to the port not granted last.
module mcac_rr_arb2
    import mcac_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic gnt_a_c,
    output logic gnt_b_c
);

    gnt_e last_grant;

    assign gnt_a_c = en && a_req && (!b_req || last_grant == GNT_B);
    assign gnt_b_c = en && b_req && (!a_req || last_grant == GNT_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_B;
        end else if (gnt_a_c) begin
            last_grant <= GNT_A;
        end else if (gnt_b_c) begin
            last_grant <= GNT_B;
        end
    end

endmodule

// File: rtl/mcac_chan_mem.sv
// Per-channel ADPCM state memory: single-port flop array shared by encoder (A)
// and decoder (B) ports, with power-up zeroing sweep and per-channel clear.
module mcac_chan_mem
    import mcac_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned NUM_CH       = 32,
    parameter int unsigned WORDS_PER_CH = 8,
    localparam int unsigned CH_W        = clog2(NUM_CH),
    localparam int unsigned WA_W        = clog2(WORDS_PER_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [CH_W-1:0]   a_ch,
    input  logic [WA_W-1:0]   a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [CH_W-1:0]   b_ch,
    input  logic [WA_W-1:0]   b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_req,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              clr_busy,
    output logic              init_done,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4
);

    localparam int unsigned IDX_W = CH_W + WA_W;
    localparam int unsigned DEPTH = NUM_CH * WORDS_PER_CH;

    state_e            state;
    logic [IDX_W-1:0]  cnt;
    logic [CH_W-1:0]   clr_ch_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              en_c;
    logic              gnt_a_c;
    logic              gnt_b_c;
    logic              a_ok_c;
    logic              b_ok_c;
    logic              clr_ok_c;
    logic [IDX_W-1:0]  a_idx_c;
    logic [IDX_W-1:0]  b_idx_c;
    logic [DATA_W-1:0] a_rd_c;
    logic [DATA_W-1:0] b_rd_c;
    logic              mem_we_c;
    logic [IDX_W-1:0]  mem_widx_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              unused_dft;

    assign scan_out0  = 1'b0;
    assign scan_out1  = 1'b0;
    assign scan_out2  = 1'b0;
    assign scan_out3  = 1'b0;
    assign scan_out4  = 1'b0;
    assign unused_dft = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode};

    // Channels beyond NUM_CH are acked but never touch the array.
    assign a_ok_c   = 32'(a_ch) < NUM_CH;
    assign b_ok_c   = 32'(b_ch) < NUM_CH;
    assign clr_ok_c = 32'(clr_ch) < NUM_CH;
    assign a_idx_c  = {a_ch, a_addr};
    assign b_idx_c  = {b_ch, b_addr};
    assign a_rd_c   = a_ok_c ? mem[a_idx_c] : '0;
    assign b_rd_c   = b_ok_c ? mem[b_idx_c] : '0;

    assign en_c  = !reset && (state == ST_IDLE);
    assign a_ack = gnt_a_c;
    assign b_ack = gnt_b_c;

    mcac_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en      (en_c),
        .a_req   (a_req),
        .b_req   (b_req),
        .gnt_a_c (gnt_a_c),
        .gnt_b_c (gnt_b_c)
    );

    // Single write port: sweep, clear, or the granted requester.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_widx_c  = '0;
        mem_wdata_c = '0;
        case (state)
            ST_INIT: begin
                mem_we_c   = 1'b1;
                mem_widx_c = cnt;
            end
            ST_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_widx_c = {clr_ch_q, cnt[WA_W-1:0]};
            end
            ST_IDLE: begin
                if (gnt_a_c && a_we && a_ok_c) begin
                    mem_we_c    = 1'b1;
                    mem_widx_c  = a_idx_c;
                    mem_wdata_c = a_wdata;
                end else if (gnt_b_c && b_we && b_ok_c) begin
                    mem_we_c    = 1'b1;
                    mem_widx_c  = b_idx_c;
                    mem_wdata_c = b_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
    end

    // FSM, sweep/clear counter and registered read returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            clr_ch_q  <= '0;
            clr_busy  <= 1'b0;
            init_done <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            a_rvalid <= gnt_a_c && !a_we;
            b_rvalid <= gnt_b_c && !b_we;
            if (gnt_a_c && !a_we) begin
                a_rdata <= a_rd_c;
            end
            if (gnt_b_c && !b_we) begin
                b_rdata <= b_rd_c;
            end
            case (state)
                ST_INIT: begin
                    if (cnt == IDX_W'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr_req && clr_ok_c) begin
                        state    <= ST_CLEAR;
                        clr_ch_q <= clr_ch;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt[WA_W-1:0] == WA_W'(WORDS_PER_CH - 1)) begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mcac_chan_mem.sv
// Directed bench for mcac_chan_mem: a default 32-channel instance plus a
// 20-channel instance sharing the same stimulus for out-of-range checks.
module tb_mcac_chan_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req, a_we, b_req, b_we, clr_req;
    logic [4:0]  a_ch, b_ch, clr_ch;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;

    logic        a_ack, b_ack, a_rvalid, b_rvalid, clr_busy, init_done;
    logic [15:0] a_rdata, b_rdata;
    logic [4:0]  so;
    logic        a_ack2, b_ack2, a_rvalid2, b_rvalid2, clr_busy2, init_done2;
    logic [15:0] a_rdata2, b_rdata2;
    logic [4:0]  so2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mcac_chan_mem dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_ch(a_ch), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_ch(b_ch), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_req(clr_req), .clr_ch(clr_ch), .clr_busy(clr_busy), .init_done(init_done),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so[0]), .scan_out1(so[1]), .scan_out2(so[2]), .scan_out3(so[3]),
        .scan_out4(so[4])
    );

    mcac_chan_mem #(.NUM_CH(20)) dut20 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_ch(a_ch), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
        .b_req(b_req), .b_we(b_we), .b_ch(b_ch), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2),
        .clr_req(clr_req), .clr_ch(clr_ch), .clr_busy(clr_busy2), .init_done(init_done2),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(so2[0]), .scan_out1(so2[1]), .scan_out2(so2[2]), .scan_out3(so2[3]),
        .scan_out4(so2[4])
    );

    // Drive one access on port p (0=A, 1=B), wait (bounded) for its ack,
    // and return the registered read result one cycle later.
    task automatic port_op(input bit p, input bit we, input logic [4:0] ch,
                           input logic [2:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output bit rv, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        if (!p) begin
            a_req = 1'b1; a_we = we; a_ch = ch; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = 1'b1; b_we = we; b_ch = ch; b_addr = addr; b_wdata = wd;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((p ? b_ack : a_ack) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rv = p ? b_rvalid : a_rvalid;
        rd = p ? b_rdata : a_rdata;
        if (!p) a_req = 1'b0; else b_req = 1'b0;
    endtask

    task automatic test_reset();
        a_req = 1'b1; a_we = 1'b0; a_ch = 5'd0; a_addr = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_ack !== 1'b0 || a_ack2 !== 1'b0) begin
            fails++; $display("FAIL reset_ack: got %b/%b expected 0/0", a_ack, a_ack2);
        end
        tests++;
        if ({b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata} !== 35'd0) begin
            fails++; $display("FAIL reset_ports: got %h expected 0",
                              {b_ack, a_rvalid, b_rvalid, a_rdata, b_rdata});
        end
        tests++;
        if ({clr_busy, init_done, so, so2} !== 12'd0) begin
            fails++; $display("FAIL reset_status: got %h expected 000",
                              {clr_busy, init_done, so, so2});
        end
        a_req = 1'b0;
    endtask

    task automatic test_powerup();
        int n = 0;
        int n20 = 0;
        bit busy_seen = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            clr_req = (k == 10);
            clr_ch  = 5'd3;
            @(posedge clk);
            #1;
            if (clr_busy || clr_busy2) busy_seen = 1'b1;
            if (init_done2 === 1'b1 && n20 == 0) n20 = k;
            if (init_done === 1'b1) begin
                n = k;
                break;
            end
            @(negedge clk);
        end
        clr_req = 1'b0;
        tests++;
        if (n != 256) begin
            fails++; $display("FAIL init_latency: got %0d expected 256", n);
        end
        tests++;
        if (n20 != 160) begin
            fails++; $display("FAIL init_latency_20ch: got %0d expected 160", n20);
        end
        tests++;
        if (busy_seen) begin
            fails++; $display("FAIL clr_during_init: got clr_busy=1 expected 0");
        end
    endtask

    task automatic test_first_tie();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_ch = 5'd0; a_addr = 3'd0;
        b_req = 1'b1; b_we = 1'b0; b_ch = 5'd0; b_addr = 3'd0;
        #1;
        tests++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            fails++; $display("FAIL first_tie: got a=%b b=%b expected a=1 b=0", a_ack, b_ack);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_zero_sweep();
        logic [15:0] rd;
        bit rv, ok;
        for (int i = 0; i < 256; i++) begin
            port_op(1'b0, 1'b0, 5'(i >> 3), 3'(i), 16'h0, rd, rv, ok);
            tests++;
            if (!ok || rv !== 1'b1 || rd !== 16'h0000) begin
                fails++; $display("FAIL zero_sweep idx %0d: ok=%0b rvalid=%b rdata=%h expected 1/1/0000",
                                  i, ok, rv, rd);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] rd;
        bit rv, ok;
        port_op(1'b0, 1'b1, 5'd5, 3'd3, 16'hBEEF, rd, rv, ok);
        tests++;
        if (!ok || rv !== 1'b0) begin
            fails++; $display("FAIL write_ack: ok=%0b rvalid=%b expected 1/0", ok, rv);
        end
        port_op(1'b1, 1'b0, 5'd5, 3'd3, 16'h0, rd, rv, ok);
        tests++;
        if (!ok || rv !== 1'b1 || rd !== 16'hBEEF) begin
            fails++; $display("FAIL b_read: ok=%0b rvalid=%b rdata=%h expected 1/1/beef", ok, rv, rd);
        end
        // B was granted last, so A takes this tie.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_ch = 5'd5; a_addr = 3'd3;
        b_req = 1'b1; b_we = 1'b0; b_ch = 5'd5; b_addr = 3'd3;
        #1;
        tests++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            fails++; $display("FAIL tie_first: got a=%b b=%b expected a=1 b=0", a_ack, b_ack);
        end
        @(posedge clk);
        #1;
        tests++;
        if (a_rvalid !== 1'b1 || a_rdata !== 16'hBEEF) begin
            fails++; $display("FAIL tie_a_data: rvalid=%b rdata=%h expected 1/beef", a_rvalid, a_rdata);
        end
        a_req = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (b_ack !== 1'b1) begin
            fails++; $display("FAIL tie_second: got b_ack=%b expected 1", b_ack);
        end
        @(posedge clk);
        #1;
        tests++;
        if (b_rvalid !== 1'b1 || b_rdata !== 16'hBEEF || a_rvalid !== 1'b0) begin
            fails++; $display("FAIL tie_b_data: b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1/beef/0",
                              b_rvalid, b_rdata, a_rvalid);
        end
        b_req = 1'b0;
    endtask

    task automatic test_fairness();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_ch = 5'd5; a_addr = 3'd3;
        b_req = 1'b1; b_we = 1'b0; b_ch = 5'd5; b_addr = 3'd3;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests++;
            if (a_ack !== ((i % 2) == 0) || b_ack !== ((i % 2) != 0)) begin
                fails++; $display("FAIL rr_cycle %0d: got a=%b b=%b expected a=%0d b=%0d",
                                  i, a_ack, b_ack, (i % 2) == 0, (i % 2) != 0);
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_clear();
        logic [15:0] rd;
        logic [15:0] exp;
        bit rv, ok;
        int busy = 0;
        int bad_ack = 0;
        for (int w = 0; w < 8; w++) begin
            port_op(1'b0, 1'b1, 5'd7, 3'(w), 16'(16'h1111 * (w + 1)), rd, rv, ok);
            port_op(1'b0, 1'b1, 5'd6, 3'(w), 16'(16'h6000 + w), rd, rv, ok);
            port_op(1'b0, 1'b1, 5'd8, 3'(w), 16'(16'h8000 + w), rd, rv, ok);
        end
        // Clear request alongside a port write that must still execute.
        @(negedge clk);
        clr_req = 1'b1; clr_ch = 5'd7;
        a_req = 1'b1; a_we = 1'b1; a_ch = 5'd6; a_addr = 3'd0; a_wdata = 16'h6A6A;
        #1;
        tests++;
        if (a_ack !== 1'b1) begin
            fails++; $display("FAIL clr_cycle_ack: got %b expected 1", a_ack);
        end
        @(posedge clk);
        #1;
        clr_req = 1'b0; a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_ch = 5'd6; b_addr = 3'd1;
        for (int k = 0; k < 20; k++) begin
            if (clr_busy !== 1'b1) break;
            busy++;
            if (b_ack !== 1'b0) bad_ack++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (busy != 8) begin
            fails++; $display("FAIL clr_busy_len: got %0d expected 8", busy);
        end
        tests++;
        if (bad_ack != 0) begin
            fails++; $display("FAIL clr_acks: got %0d acks expected 0", bad_ack);
        end
        tests++;
        if (b_ack !== 1'b1) begin
            fails++; $display("FAIL clr_end_ack: got %b expected 1", b_ack);
        end
        @(posedge clk);
        #1;
        tests++;
        if (b_rvalid !== 1'b1 || b_rdata !== 16'h6001) begin
            fails++; $display("FAIL clr_end_read: rvalid=%b rdata=%h expected 1/6001", b_rvalid, b_rdata);
        end
        b_req = 1'b0;
        for (int w = 0; w < 8; w++) begin
            port_op(1'b0, 1'b0, 5'd7, 3'(w), 16'h0, rd, rv, ok);
            tests++;
            if (!ok || rd !== 16'h0000) begin
                fails++; $display("FAIL ch7 word %0d: got %h expected 0000", w, rd);
            end
            exp = (w == 0) ? 16'h6A6A : 16'(16'h6000 + w);
            port_op(1'b0, 1'b0, 5'd6, 3'(w), 16'h0, rd, rv, ok);
            tests++;
            if (!ok || rd !== exp) begin
                fails++; $display("FAIL ch6 word %0d: got %h expected %h", w, rd, exp);
            end
            exp = 16'(16'h8000 + w);
            port_op(1'b0, 1'b0, 5'd8, 3'(w), 16'h0, rd, rv, ok);
            tests++;
            if (!ok || rd !== exp) begin
                fails++; $display("FAIL ch8 word %0d: got %h expected %h", w, rd, exp);
            end
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_ch = 5'd25; a_addr = 3'd2; a_wdata = 16'hDEAD;
        #1;
        tests++;
        if (a_ack2 !== 1'b1) begin
            fails++; $display("FAIL oor_write_ack: got %b expected 1", a_ack2);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0;
        #1;
        tests++;
        if (a_ack2 !== 1'b1) begin
            fails++; $display("FAIL oor_read_ack: got %b expected 1", a_ack2);
        end
        @(posedge clk);
        #1;
        tests++;
        if (a_rvalid2 !== 1'b1 || a_rdata2 !== 16'h0000) begin
            fails++; $display("FAIL oor_read_data: rvalid=%b rdata=%h expected 1/0000", a_rvalid2, a_rdata2);
        end
        tests++;
        if (a_rdata !== 16'hDEAD) begin
            fails++; $display("FAIL inrange_32ch_read: got %h expected dead", a_rdata);
        end
        a_req = 1'b0;
        @(negedge clk);
        clr_req = 1'b1; clr_ch = 5'd25;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        tests++;
        if (clr_busy2 !== 1'b0 || clr_busy !== 1'b1) begin
            fails++; $display("FAIL oor_clear: busy20=%b busy32=%b expected 0/1", clr_busy2, clr_busy);
        end
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_ch = 5'd25; a_addr = 3'd2;
        #1;
        tests++;
        if (a_ack2 !== 1'b1 || a_ack !== 1'b0) begin
            fails++; $display("FAIL oor_clear_idle: ack20=%b ack32=%b expected 1/0", a_ack2, a_ack);
        end
        @(posedge clk);
        #1;
        a_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        @(negedge clk);
        clr_req = 1'b1; clr_ch = 5'd9;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (clr_busy !== 1'b1) begin
            fails++; $display("FAIL midclr_busy: got %b expected 1", clr_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (clr_busy !== 1'b0 || init_done !== 1'b0 || a_rvalid !== 1'b0) begin
            fails++; $display("FAIL midclr_reset: busy=%b init_done=%b rvalid=%b expected 0/0/0",
                              clr_busy, init_done, a_rvalid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (init_done === 1'b1) begin
                n = k;
                break;
            end
        end
        tests++;
        if (n != 256) begin
            fails++; $display("FAIL resweep_latency: got %0d expected 256", n);
        end
    endtask

    initial begin
        a_req = 1'b0; a_we = 1'b0; a_ch = '0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_ch = '0; b_addr = '0; b_wdata = '0;
        clr_req = 1'b0; clr_ch = '0;
        test_reset();
        test_powerup();
        test_first_tie();
        test_zero_sweep();
        test_write_read();
        test_fairness();
        test_clear();
        test_out_of_range();
        test_reset_mid_clear();
        test_zero_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
